// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for a 32-bit scalar, MSB first.
// Optional macro DUMMY_ADD_EN issues discarded additions on zero bits for uniform timing.
module scalar_mult_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_key_bit,
    output logic       o_bit_req,
    input  logic       i_bit_ack,
    output logic       o_dbl_start,
    output logic       o_add_start,
    output logic       o_dummy,
    output logic       o_load,
    input  logic       i_op_done,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_q_inf,
    output logic [5:0] o_bit_cnt
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(31);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_DBL, S_WAIT_DBL, S_ADD,
        S_WAIT_ADD, S_NEXT, S_WAIT_ACK, S_FINISH
    } state_t;

    state_t           r_state;
    logic             r_bit;
    logic             r_q_inf;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_bit_req;
    logic             r_dbl_start;
    logic             r_add_start;
    logic             r_load;
`ifdef DUMMY_ADD_EN
    logic             r_dummy;
`endif

    // Sequencer: every pulse output defaults low and is raised for exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_bit       <= 1'b0;
            r_q_inf     <= 1'b1;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bit_req   <= 1'b0;
            r_dbl_start <= 1'b0;
            r_add_start <= 1'b0;
            r_load      <= 1'b0;
`ifdef DUMMY_ADD_EN
            r_dummy     <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_bit_req   <= 1'b0;
            r_dbl_start <= 1'b0;
            r_add_start <= 1'b0;
            r_load      <= 1'b0;
`ifdef DUMMY_ADD_EN
            r_dummy     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_q_inf   <= 1'b1;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_bit   <= i_key_bit;
                    r_state <= r_q_inf ? S_ADD : S_DBL;
                end
                S_DBL: begin
                    r_dbl_start <= 1'b1;
                    r_state     <= S_WAIT_DBL;
                end
                S_WAIT_DBL: begin
                    if (i_op_done) r_state <= S_ADD;
                end
                S_ADD: begin
                    if (r_q_inf) begin
                        // Q is infinity: a set bit just copies P, no arithmetic needed.
                        if (r_bit) begin
                            r_load  <= 1'b1;
                            r_q_inf <= 1'b0;
                        end
                        r_state <= S_NEXT;
                    end else if (r_bit) begin
                        r_add_start <= 1'b1;
                        r_state     <= S_WAIT_ADD;
                    end else begin
`ifdef DUMMY_ADD_EN
                        r_add_start <= 1'b1;
                        r_dummy     <= 1'b1;
                        r_state     <= S_WAIT_ADD;
`else
                        r_state     <= S_NEXT;
`endif
                    end
                end
                S_WAIT_ADD: begin
                    if (i_op_done) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_IDX) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_bit_req <= 1'b1;
                        r_state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (i_bit_ack) begin
                        r_bit   <= i_key_bit;
                        r_state <= r_q_inf ? S_ADD : S_DBL;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bit_req   = r_bit_req;
    assign o_dbl_start = r_dbl_start;
    assign o_add_start = r_add_start;
    assign o_load      = r_load;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_q_inf     = r_q_inf;
    assign o_bit_cnt   = r_bit_cnt;
`ifdef DUMMY_ADD_EN
    assign o_dummy     = r_dummy;
`else
    assign o_dummy     = 1'b0;
`endif

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl: key shifter and arithmetic-unit models plus pulse counters.
module tb_scalar_mult_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_key_bit = 1'b0;
    logic       i_bit_ack = 1'b0;
    logic       i_op_done;
    logic       o_bit_req, o_dbl_start, o_add_start, o_dummy, o_load;
    logic       o_busy, o_done, o_q_inf;
    logic [5:0] o_bit_cnt;

    logic       m_done = 1'b0;
    logic       tb_inject = 1'b0;
    assign i_op_done = m_done | tb_inject;

    scalar_mult_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_key_bit(i_key_bit),
        .o_bit_req(o_bit_req), .i_bit_ack(i_bit_ack), .o_dbl_start(o_dbl_start),
        .o_add_start(o_add_start), .o_dummy(o_dummy), .o_load(o_load),
        .i_op_done(i_op_done), .o_busy(o_busy), .o_done(o_done),
        .o_q_inf(o_q_inf), .o_bit_cnt(o_bit_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Key shifter: presents bit 31 with start, then one bit per request, acked next edge.
    logic [31:0] key_val = '0;
    int start_seq = 0;
    int seen_seq = 0;
    int key_idx = 31;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            i_start   = 1'b0;
            i_bit_ack = 1'b0;
            key_idx   = 31;
            seen_seq  = start_seq;
        end else begin
            i_start   = 1'b0;
            i_bit_ack = 1'b0;
            if (start_seq != seen_seq) begin
                seen_seq  = start_seq;
                key_idx   = 31;
                i_key_bit = key_val[key_idx];
                i_start   = 1'b1;
            end else if (o_bit_req && key_idx > 0) begin
                key_idx   = key_idx - 1;
                i_key_bit = key_val[key_idx];
                i_bit_ack = 1'b1;
            end
        end
    end

    // Arithmetic unit: completion pulse 'lat' cycles after a launch.
    int lat = 1;
    int pend = 0;
    always @(negedge i_clk) begin
        m_done = 1'b0;
        if (!i_rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) m_done = 1'b1;
            end
            if (o_dbl_start || o_add_start) begin
                pend = lat - 1;
                if (pend == 0) m_done = 1'b1;
            end
        end
    end

    int n_dbl = 0, n_add = 0, n_dum = 0, n_load = 0, n_req = 0, n_done = 0, n_ovl = 0;
    int q_inf_at_done = 0, cnt_at_done = 0;
    always @(negedge i_clk) begin
        if (o_dbl_start) n_dbl++;
        if (o_add_start) n_add++;
        if (o_add_start && o_dummy) n_dum++;
        if (o_load) n_load++;
        if (o_bit_req) n_req++;
        if ((32'(o_dbl_start) + 32'(o_add_start) + 32'(o_load) + 32'(o_bit_req)) > 1) n_ovl++;
        if (o_done) begin
            n_done++;
            q_inf_at_done = 32'(o_q_inf);
            cnt_at_done   = 32'(o_bit_cnt);
        end
    end

    task automatic run_key(input string name, input logic [31:0] k, input int l,
                           input int e_load, input int e_dbl, input int e_add, input int e_zero);
        int s_dbl, s_add, s_dum, s_load, s_req, s_done, s_ovl, cyc, x_add, x_dum;
        s_dbl = n_dbl; s_add = n_add; s_dum = n_dum; s_load = n_load;
        s_req = n_req; s_done = n_done; s_ovl = n_ovl;
`ifdef DUMMY_ADD_EN
        x_add = e_add + e_zero;
        x_dum = e_zero;
`else
        x_add = e_add;
        x_dum = 0;
`endif
        lat = l;
        key_val = k;
        start_seq++;
        cyc = 0;
        while (n_done == s_done && cyc < 5000) begin
            @(negedge i_clk);
            cyc++;
        end
        @(negedge i_clk);
        check_eq({name, "_done"}, n_done - s_done, 1);
        check_eq({name, "_load"}, n_load - s_load, e_load);
        check_eq({name, "_dbl"}, n_dbl - s_dbl, e_dbl);
        check_eq({name, "_add"}, n_add - s_add, x_add);
        check_eq({name, "_dummy"}, n_dum - s_dum, x_dum);
        check_eq({name, "_req"}, n_req - s_req, 31);
        check_eq({name, "_overlap"}, n_ovl - s_ovl, 0);
        check_eq({name, "_qinf"}, q_inf_at_done, (k == 32'd0) ? 1 : 0);
        check_eq({name, "_cnt"}, cnt_at_done, 32);
        check_eq({name, "_busy_after"}, 32'(o_busy), 0);
        check_eq({name, "_cnt_hold"}, 32'(o_bit_cnt), 32);
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        int cyc, found, s_dbl, s_add, s_load, s_req, s_done;
        repeat (3) @(negedge i_clk);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_cnt", 32'(o_bit_cnt), 0);
        check_eq("rst_qinf", 32'(o_q_inf), 1);
        check_eq("rst_done", 32'(o_done), 0);
        check_eq("rst_dummy", 32'(o_dummy), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        run_key("ones", 32'hFFFF_FFFF, 1, 1, 31, 31, 0);
        run_key("zero", 32'h0000_0000, 1, 0, 0, 0, 0);
        run_key("lsb", 32'h0000_0001, 2, 1, 0, 0, 0);
        run_key("msb", 32'h8000_0000, 1, 1, 31, 0, 31);
        run_key("a5", 32'h0000_00A5, 3, 1, 7, 3, 4);
        run_key("f0", 32'hF0F0_F0F0, 2, 1, 31, 15, 16);

        // Abort a run while a doubling is in flight at bit 10.
        lat = 5;
        key_val = 32'hFFFF_FFFF;
        start_seq++;
        found = 0;
        cyc = 0;
        while (found == 0 && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            if (o_dbl_start && o_bit_cnt == 6'd10) found = 1;
        end
        check_eq("abort_reach_bit10", found, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(o_busy), 0);
        check_eq("abort_cnt", 32'(o_bit_cnt), 0);
        check_eq("abort_qinf", 32'(o_q_inf), 1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        s_dbl = n_dbl; s_add = n_add; s_load = n_load; s_req = n_req; s_done = n_done;
        tb_inject = 1'b1;
        @(negedge i_clk);
        tb_inject = 1'b0;
        repeat (5) @(negedge i_clk);
        check_eq("abort_stray_pulses",
                 (n_dbl - s_dbl) + (n_add - s_add) + (n_load - s_load) + (n_req - s_req) + (n_done - s_done), 0);
        check_eq("abort_idle_busy", 32'(o_busy), 0);

        run_key("rerun", 32'hFFFF_FFFF, 1, 1, 31, 31, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
